// File: rtl/m_pkg.sv
// Shared definitions for the PCPI front end of the RV32M execution unit:
// FSM state encoding, RV32M decode constants and the default custom opcode.
package m_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  localparam logic [6:0] OPCODE_OP             = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV         = 7'b0000001;
  localparam logic [6:0] CUSTOM_OPCODE_DEFAULT = 7'b0001011;

  // True for any of the eight RV32M register-register operations.
  function automatic logic is_rv32m(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV);
  endfunction

endpackage

// File: rtl/m_decode.sv
// Instruction filter: flags the instructions this co-processor claims.
// Everything else is left for the core to trap.
module m_decode
  import m_pkg::*;
#(
  parameter logic [6:0] CUSTOM_OPCODE = CUSTOM_OPCODE_DEFAULT
) (
  input  logic [31:0] insn,
  output logic        accepted
);

  // RV32M ops or anything carrying the custom opcode.
  always_comb begin
    accepted = is_rv32m(insn) || (insn[6:0] == CUSTOM_OPCODE);
  end

endmodule

// File: rtl/m_pcpi_frontend.sv
// PCPI front end: accepts RV32M / custom-0 requests from the core, issues
// them to the M execution unit, waits for the result (with a timeout) and
// returns it to the core. Aborted or timed-out operations are drained so
// a late result from the M unit can never leak into a later request.
module m_pcpi_frontend
  import m_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [6:0] CUSTOM_OPCODE  = CUSTOM_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic        m_valid,
  output logic [31:0] m_instruction,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_busy,
  input  logic        m_ready,
  output logic        err_timeout,
  output logic [15:0] op_count
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      state_reg, state_next;
  logic [31:0] insn_reg, rs1_reg, rs2_reg;
  logic [31:0] rd_reg;
  logic        wr_pend_reg;
  logic        wait_reg;
  logic        to_resp_reg;
  logic        err_reg;
  logic [15:0] count_reg;
  logic [CNT_W-1:0] wait_cnt_reg;

  logic accepted;
  logic take_result;
  logic timeout_fire;

  m_decode #(
    .CUSTOM_OPCODE(CUSTOM_OPCODE)
  ) u_decode (
    .insn    (pcpi_insn),
    .accepted(accepted)
  );

  // A result is only kept when the core is still waiting for it; m_ready
  // beats a timeout that lands in the same cycle.
  always_comb begin
    take_result  = (state_reg == ST_WAIT) && m_ready && pcpi_valid;
    timeout_fire = (state_reg == ST_WAIT) && pcpi_valid && !m_ready &&
                   (wait_cnt_reg == WAIT_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (pcpi_valid && accepted) state_next = ST_ISSUE;
      ST_ISSUE: state_next = pcpi_valid ? ST_WAIT : ST_DRAIN;
      ST_WAIT: begin
        if (!pcpi_valid)       state_next = m_ready ? ST_IDLE : ST_DRAIN;
        else if (m_ready)      state_next = ST_RESP;
        else if (timeout_fire) state_next = ST_DRAIN;
      end
      ST_RESP:  state_next = ST_HOLD;
      ST_HOLD:  if (!pcpi_valid) state_next = ST_IDLE;
      ST_DRAIN: if (m_ready || !m_busy) state_next = pcpi_valid ? ST_HOLD : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode; the timeout response reports a zero result.
  always_comb begin
    m_valid       = (state_reg == ST_ISSUE);
    pcpi_ready    = (state_reg == ST_RESP) || to_resp_reg;
    pcpi_wr       = (state_reg == ST_RESP) && wr_pend_reg;
    pcpi_rd       = to_resp_reg ? 32'h0 : rd_reg;
    pcpi_wait     = wait_reg;
    m_instruction = insn_reg;
    m_rs1         = rs1_reg;
    m_rs2         = rs2_reg;
    err_timeout   = err_reg;
    op_count      = count_reg;
  end

  // Holding registers, captured once when a request is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      insn_reg <= '0;
      rs1_reg  <= '0;
      rs2_reg  <= '0;
    end else if (state_reg == ST_IDLE && state_next == ST_ISSUE) begin
      insn_reg <= pcpi_insn;
      rs1_reg  <= pcpi_rs1;
      rs2_reg  <= pcpi_rs2;
    end
  end

  // Result capture from the M unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_reg      <= '0;
      wr_pend_reg <= 1'b0;
    end else if (take_result) begin
      rd_reg      <= m_rd;
      wr_pend_reg <= m_wr;
    end
  end

  // WAIT cycle counter, cleared whenever WAIT is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                             wait_cnt_reg <= '0;
    else if (state_reg != ST_WAIT && state_next == ST_WAIT) wait_cnt_reg <= '0;
    else if (state_reg == ST_WAIT)                          wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
  end

  // Registered busy indication and timeout response / sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_reg    <= 1'b0;
      to_resp_reg <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      wait_reg    <= (state_next == ST_ISSUE) || (state_next == ST_WAIT);
      to_resp_reg <= timeout_fire;
      err_reg     <= err_reg | timeout_fire;
    end
  end

  // Completed-operation counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count_reg <= '0;
    else if (state_reg == ST_RESP) count_reg <= count_reg + 16'd1;
  end

endmodule

// File: tb/tb_m_pcpi_frontend.sv
// Bench for m_pcpi_frontend: a behavioural core/M-unit pair drives requests
// and the bench compares responses with an RV32M arithmetic reference.
module tb_m_pcpi_frontend;

  localparam int         TO   = 8;
  localparam logic [6:0] CUST = 7'b0001011;
  localparam logic [6:0] OP   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = '0, pcpi_rs1 = '0, pcpi_rs2 = '0;
  logic        pcpi_wr, pcpi_wait, pcpi_ready, m_valid, err_timeout;
  logic [31:0] pcpi_rd, m_instruction, m_rs1, m_rs2;
  logic [15:0] op_count;
  logic        m_wr = 1'b0, m_busy = 1'b0, m_ready = 1'b0;
  logic [31:0] m_rd = '0;

  m_pcpi_frontend #(.TIMEOUT_CYCLES(TO), .CUSTOM_OPCODE(CUST)) dut (
    .clk(clk), .reset(reset),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd), .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .m_valid(m_valid), .m_instruction(m_instruction), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_wr(m_wr), .m_rd(m_rd), .m_busy(m_busy), .m_ready(m_ready),
    .err_timeout(err_timeout), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [15:0] op_ref = '0;

  // Observations of the last transaction.
  int          r_mv_n, r_mv_at, r_rdy_n, r_rdy_at, r_wait_n, r_last_wait;
  logic [31:0] r_rd;
  logic        r_wr;
  bit          r_bound;

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, 5'd3, opc};
  endfunction

  // Architectural result of an RV32M op; custom-0 is defined as a+b+0x100.
  function automatic logic [31:0] m_model(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = $signed(a); sb = $signed(b);
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    if (insn[6:0] != OP) return a + b + 32'h100;
    case (insn[14:12])
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Plays core and M unit for one request. Cycle 0 is the cycle in which
  // pcpi_valid is first sampled; observation c is taken just after edge c.
  // lat: M result arrives lat cycles after the m_valid cycle.
  // drop_c: core drops valid in cycle drop_c (-1: never early).
  // hold_after: extra cycles valid stays high after pcpi_ready.
  // give_up: cycle at which the core gives up if nothing was issued.
  task automatic run_txn(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int drop_c, input int hold_after,
                         input int give_up, input bit wr_give);
    bit v, done;
    int low_n, fire_c;
    r_mv_n = 0; r_mv_at = -1; r_rdy_n = 0; r_rdy_at = -1; r_wait_n = 0; r_last_wait = -1;
    r_rd = '0; r_wr = 1'b0; r_bound = 1'b0;
    v = 1'b1; done = 1'b0; low_n = 0; fire_c = -1;
    pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b;
    for (int c = 1; c <= 150 && !done; c++) begin
      @(posedge clk); #1;
      if (m_valid)    begin r_mv_n++; if (r_mv_at < 0) r_mv_at = c; end
      if (pcpi_ready) begin r_rdy_n++; r_rdy_at = c; r_rd = pcpi_rd; r_wr = pcpi_wr; end
      if (pcpi_wait)  begin r_wait_n++; r_last_wait = c; end
      if (m_ready) begin m_ready = 1'b0; m_wr = 1'b0; m_busy = 1'b0; end
      if (m_valid) begin m_busy = 1'b1; fire_c = c + lat; end
      if (m_busy && c == fire_c) begin
        m_ready = 1'b1; m_wr = wr_give; m_rd = m_model(insn, a, b);
      end else begin
        m_rd = $urandom;
      end
      if (drop_c >= 0 && c >= drop_c) v = 1'b0;
      if (r_rdy_at >= 0 && c >= r_rdy_at + 1 + hold_after) v = 1'b0;
      if (r_mv_n == 0 && c >= give_up) v = 1'b0;
      pcpi_valid = v;
      if (!v) low_n++;
      if (!v && !m_busy && !m_ready && low_n >= 3) done = 1'b1;
    end
    if (!done) r_bound = 1'b1;
    pcpi_valid = 1'b0; m_ready = 1'b0; m_busy = 1'b0; m_wr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    total++; if ({pcpi_wr, pcpi_ready, pcpi_wait, m_valid, err_timeout} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {pcpi_wr, pcpi_ready, pcpi_wait, m_valid, err_timeout}); end
    total++; if ({pcpi_rd, m_instruction, m_rs1, m_rs2, op_count} !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", {pcpi_rd, m_instruction, m_rs1, m_rs2, op_count}); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    op_ref = '0;
    $display("txn reset: flags=%b op_count=%0d", {pcpi_wr, pcpi_ready, pcpi_wait, m_valid, err_timeout}, op_count);
  endtask

  task automatic test_mul();
    logic [31:0] insn;
    insn = mk(7'h01, 3'd0, OP);
    run_txn(insn, 32'd7, 32'd6, 1, -1, 0, 40, 1'b1);
    op_ref++;
    $display("txn mul: mv_at=%0d rdy_at=%0d rd=%0d wr=%0d op_count=%0d", r_mv_at, r_rdy_at, r_rd, r_wr, op_count);
    total++; if (r_bound)         begin bad++; $display("FAIL mul_bound got=expired want=completed"); end
    total++; if (r_mv_n !== 1 || r_mv_at !== 1) begin bad++; $display("FAIL mul_mvalid got n=%0d at=%0d want n=1 at=1", r_mv_n, r_mv_at); end
    total++; if (r_rdy_n !== 1 || r_rdy_at !== 3) begin bad++; $display("FAIL mul_ready got n=%0d at=%0d want n=1 at=3", r_rdy_n, r_rdy_at); end
    total++; if (r_rd !== 32'd42 || r_wr !== 1'b1) begin bad++; $display("FAIL mul_result got rd=%0d wr=%b want rd=42 wr=1", r_rd, r_wr); end
    total++; if (r_wait_n !== 2)  begin bad++; $display("FAIL mul_wait got=%0d want=2", r_wait_n); end
    total++; if (op_count !== op_ref) begin bad++; $display("FAIL mul_opcount got=%0d want=%0d", op_count, op_ref); end
  endtask

  task automatic test_reject_add();
    run_txn(mk(7'h00, 3'd0, OP), 32'd1, 32'd2, 1, -1, 0, 20, 1'b1);
    $display("txn add: mv=%0d wait=%0d ready=%0d", r_mv_n, r_wait_n, r_rdy_n);
    total++; if (r_bound) begin bad++; $display("FAIL add_bound got=expired want=completed"); end
    total++; if (r_mv_n !== 0 || r_wait_n !== 0 || r_rdy_n !== 0) begin bad++; $display("FAIL add_reject got mv=%0d wait=%0d rdy=%0d want 0/0/0", r_mv_n, r_wait_n, r_rdy_n); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      logic [31:0] insn, a, b, exp;
      bit acc, wrg;
      int lat;
      acc = ($urandom_range(0, 3) != 0);
      if (acc) begin
        if ($urandom_range(0, 7) == 0) insn = mk(7'($urandom), 3'($urandom), CUST);
        else                           insn = mk(7'h01, 3'($urandom), OP);
      end else begin
        case ($urandom_range(0, 2))
          0:       insn = mk(7'h00, 3'($urandom), OP);
          1:       insn = mk(7'h20, 3'($urandom), OP);
          default: insn = mk(7'($urandom), 3'($urandom), 7'b0010011);
        endcase
      end
      a = rnd_op(); b = rnd_op();
      lat = $urandom_range(1, 6);
      wrg = 1'($urandom_range(0, 1));
      run_txn(insn, a, b, lat, -1, 0, 6, wrg);
      exp = m_model(insn, a, b);
      if (acc) op_ref++;
      $display("txn rand%0d: insn=%h a=%h b=%h lat=%0d acc=%0d rdy_at=%0d rd=%h wr=%0d", k, insn, a, b, lat, acc, r_rdy_at, r_rd, r_wr);
      total++; if (r_bound) begin bad++; $display("FAIL rand%0d_bound got=expired want=completed", k); end
      if (acc) begin
        total++; if (r_mv_n !== 1 || r_rdy_n !== 1 || r_rdy_at !== 2 + lat) begin bad++; $display("FAIL rand%0d_timing got mv=%0d rdy=%0d at=%0d want 1/1/%0d", k, r_mv_n, r_rdy_n, r_rdy_at, 2 + lat); end
        total++; if (r_rd !== exp || r_wr !== wrg) begin bad++; $display("FAIL rand%0d_result got rd=%h wr=%b want rd=%h wr=%b", k, r_rd, r_wr, exp, wrg); end
      end else begin
        total++; if (r_mv_n !== 0 || r_rdy_n !== 0 || r_wait_n !== 0) begin bad++; $display("FAIL rand%0d_reject got mv=%0d rdy=%0d wait=%0d want 0/0/0", k, r_mv_n, r_rdy_n, r_wait_n); end
      end
      total++; if (op_count !== op_ref) begin bad++; $display("FAIL rand%0d_opcount got=%0d want=%0d", k, op_count, op_ref); end
    end
  endtask

  // Result lands in the last allowed WAIT cycle: must complete normally.
  task automatic test_ready_at_timeout();
    logic [31:0] insn;
    insn = mk(7'h01, 3'd1, OP);
    run_txn(insn, 32'hDEAD_BEEF, 32'h1234_5678, TO, -1, 0, 40, 1'b1);
    op_ref++;
    $display("txn edge: rdy_at=%0d rd=%h wr=%0d err=%0d", r_rdy_at, r_rd, r_wr, err_timeout);
    total++; if (r_rdy_n !== 1 || r_rdy_at !== 2 + TO) begin bad++; $display("FAIL edge_ready got n=%0d at=%0d want n=1 at=%0d", r_rdy_n, r_rdy_at, 2 + TO); end
    total++; if (r_rd !== m_model(insn, 32'hDEAD_BEEF, 32'h1234_5678) || r_wr !== 1'b1) begin bad++; $display("FAIL edge_result got rd=%h wr=%b", r_rd, r_wr); end
    total++; if (err_timeout !== 1'b0 || op_count !== op_ref) begin bad++; $display("FAIL edge_status got err=%b cnt=%0d want err=0 cnt=%0d", err_timeout, op_count, op_ref); end
  endtask

  task automatic test_timeout();
    run_txn(mk(7'h01, 3'd5, OP), 32'd100, 32'd7, TO + 12, -1, 0, 40, 1'b1);
    $display("txn timeout: rdy_at=%0d rd=%h wr=%0d err=%0d op_count=%0d", r_rdy_at, r_rd, r_wr, err_timeout, op_count);
    total++; if (r_bound) begin bad++; $display("FAIL timeout_bound got=expired want=completed"); end
    total++; if (r_rdy_n !== 1 || r_rdy_at !== 2 + TO) begin bad++; $display("FAIL timeout_ready got n=%0d at=%0d want n=1 at=%0d", r_rdy_n, r_rdy_at, 2 + TO); end
    total++; if (r_rd !== 32'h0 || r_wr !== 1'b0) begin bad++; $display("FAIL timeout_result got rd=%h wr=%b want rd=0 wr=0", r_rd, r_wr); end
    total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_err got=%b want=1", err_timeout); end
    total++; if (op_count !== op_ref) begin bad++; $display("FAIL timeout_opcount got=%0d want=%0d", op_count, op_ref); end
  endtask

  task automatic test_abort();
    logic [31:0] insn;
    run_txn(mk(7'h01, 3'd3, OP), 32'd9, 32'd9, 8, 4, 0, 40, 1'b1);
    $display("txn abort: rdy=%0d last_wait=%0d", r_rdy_n, r_last_wait);
    total++; if (r_bound) begin bad++; $display("FAIL abort_bound got=expired want=completed"); end
    total++; if (r_rdy_n !== 0) begin bad++; $display("FAIL abort_ready got=%0d want=0", r_rdy_n); end
    total++; if (r_last_wait !== 4) begin bad++; $display("FAIL abort_wait_drop got last=%0d want=4", r_last_wait); end
    insn = mk(7'h01, 3'd1, OP);
    run_txn(insn, 32'h8000_0000, 32'h8000_0000, 2, -1, 0, 40, 1'b1);
    op_ref++;
    $display("txn mulh: mv_at=%0d rdy_at=%0d rd=%h", r_mv_at, r_rdy_at, r_rd);
    total++; if (r_mv_at !== 1 || r_rdy_at !== 4) begin bad++; $display("FAIL mulh_timing got mv=%0d rdy=%0d want 1/4", r_mv_at, r_rdy_at); end
    total++; if (r_rd !== 32'h4000_0000 || op_count !== op_ref) begin bad++; $display("FAIL mulh_result got rd=%h cnt=%0d want rd=40000000 cnt=%0d", r_rd, op_count, op_ref); end
  endtask

  task automatic test_hold();
    run_txn(mk(7'h01, 3'd7, OP), 32'd17, 32'd5, 1, -1, 3, 40, 1'b1);
    op_ref++;
    $display("txn hold: mv=%0d rdy=%0d rd=%0d", r_mv_n, r_rdy_n, r_rd);
    total++; if (r_mv_n !== 1 || r_rdy_n !== 1) begin bad++; $display("FAIL hold_pulses got mv=%0d rdy=%0d want 1/1", r_mv_n, r_rdy_n); end
    total++; if (r_rd !== 32'd2 || op_count !== op_ref) begin bad++; $display("FAIL hold_result got rd=%0d cnt=%0d want rd=2 cnt=%0d", r_rd, op_count, op_ref); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] insn;
    insn = mk(7'h01, 3'd5, OP);
    pcpi_valid = 1'b1; pcpi_insn = insn; pcpi_rs1 = 32'hCAFE_0001; pcpi_rs2 = 32'd3;
    @(posedge clk); #1;
    m_busy = 1'b1;
    @(posedge clk); #1;
    total++; if (pcpi_wait !== 1'b1 || m_rs1 !== 32'hCAFE_0001 || m_instruction !== insn) begin bad++; $display("FAIL rstw_pre got wait=%b rs1=%h insn=%h", pcpi_wait, m_rs1, m_instruction); end
    #2 reset = 1'b1;
    #1;
    $display("txn reset_wait: flags=%b rd=%h op_count=%0d", {pcpi_wr, pcpi_ready, pcpi_wait, m_valid, err_timeout}, pcpi_rd, op_count);
    total++; if ({pcpi_wr, pcpi_ready, pcpi_wait, m_valid, err_timeout} !== 5'b0) begin bad++; $display("FAIL rstw_flags got=%b want=00000", {pcpi_wr, pcpi_ready, pcpi_wait, m_valid, err_timeout}); end
    total++; if ({pcpi_rd, m_instruction, m_rs1, m_rs2, op_count} !== '0) begin bad++; $display("FAIL rstw_data got=%h want=0", {pcpi_rd, m_instruction, m_rs1, m_rs2, op_count}); end
    pcpi_valid = 1'b0; m_busy = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    op_ref = '0;
    @(posedge clk); #1;
    total++; if (pcpi_ready !== 1'b0 || pcpi_wait !== 1'b0) begin bad++; $display("FAIL rstw_post got ready=%b wait=%b want 0/0", pcpi_ready, pcpi_wait); end
    insn = mk(7'h15, 3'd2, CUST);
    run_txn(insn, 32'd1, 32'd1, 3, -1, 0, 40, 1'b1);
    op_ref++;
    $display("txn custom: rdy_at=%0d rd=%h op_count=%0d", r_rdy_at, r_rd, op_count);
    total++; if (r_rdy_n !== 1 || r_rdy_at !== 5) begin bad++; $display("FAIL custom_ready got n=%0d at=%0d want n=1 at=5", r_rdy_n, r_rdy_at); end
    total++; if (r_rd !== 32'h102 || op_count !== op_ref) begin bad++; $display("FAIL custom_result got rd=%h cnt=%0d want rd=102 cnt=%0d", r_rd, op_count, op_ref); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_reject_add();
    test_random();
    test_ready_at_timeout();
    test_timeout();
    test_abort();
    test_hold();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
